gpr_writeback: RTL and testbench

Writeback collector that sits in front of the general-purpose register file write port and acts as its writer. It accepts results from the ALU and LSU over valid/ready handshakes and buffers them in an in-order FIFO. It retires one write per cycle onto the register file write port. It also reports pending-write hazards, with optional forwarding, for the two register read addresses issued by decode.

---
 rtl/gpr_writeback.sv | 139 +++++++++++++
 tb/tb_gpr_writeback.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_writeback.sv
// Writeback collector in front of the GPR write port: buffers ALU/LSU
// results in order, retires one per cycle, reports rs1/rs2 hazards.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   alu_* / lsu_*              valid/ready result inputs (LSU has priority)
//   reg_wen_o/waddr_o/wdata_o  register file write port (head of FIFO)
//   rs1/rs2_addr_i             decode read addresses
//   rs1/rs2_pend_o             buffered write to that address pending
//   rs1/rs2_fwd_o              youngest pending data (WB_BYPASS_EN only)
//   wb_empty_o, wb_full_o      FIFO status
// Optional build macro: WB_BYPASS_EN enables the forwarding search.
module gpr_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_waddr_i,
  input  logic [DATA_W-1:0] alu_wdata_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_waddr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              reg_wen_o,
  output logic [ADDR_W-1:0] reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic              rs1_pend_o,
  output logic              rs2_pend_o,
  output logic [DATA_W-1:0] rs1_fwd_o,
  output logic [DATA_W-1:0] rs2_fwd_o,
  output logic              wb_empty_o,
  output logic              wb_full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic              full;
  logic              empty;
  logic              lsu_fire;
  logic              alu_fire;
  logic              enq;
  logic              deq;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign lsu_ready_o = !wb_rst_i && !full;
  assign alu_ready_o = !wb_rst_i && !full && !lsu_valid_i;

  assign lsu_fire = lsu_valid_i && lsu_ready_o;
  assign alu_fire = alu_valid_i && alu_ready_o;

  always_comb begin
    enq_addr = alu_waddr_i;
    enq_data = alu_wdata_i;
    if (lsu_fire) begin
      enq_addr = lsu_waddr_i;
      enq_data = lsu_wdata_i;
    end
  end

  // x0 writes complete the handshake but are dropped here.
  assign enq = (lsu_fire || alu_fire) && (enq_addr != '0);
  assign deq = !empty;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry contents are deliberately not reset.
  always_ff @(posedge wb_clk_i) begin
    if (enq) begin
      mem_addr[wr_ptr] <= enq_addr;
      mem_data[wr_ptr] <= enq_data;
    end
  end

  assign reg_wen_o   = deq;
  assign reg_waddr_o = empty ? '0 : mem_addr[rd_ptr];
  assign reg_wdata_o = empty ? '0 : mem_data[rd_ptr];
  assign wb_empty_o  = empty;
  assign wb_full_o   = full;

  // Walk head to tail; a later match overwrites, so the youngest wins.
  always_comb begin
    logic [PW-1:0] idx;
    rs1_pend_o = 1'b0;
    rs2_pend_o = 1'b0;
    rs1_fwd_o  = '0;
    rs2_fwd_o  = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count) begin
        if (rs1_addr_i != '0 && mem_addr[idx] == rs1_addr_i) begin
          rs1_pend_o = 1'b1;
`ifdef WB_BYPASS_EN
          rs1_fwd_o  = mem_data[idx];
`endif
        end
        if (rs2_addr_i != '0 && mem_addr[idx] == rs2_addr_i) begin
          rs2_pend_o = 1'b1;
`ifdef WB_BYPASS_EN
          rs2_fwd_o  = mem_data[idx];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed self-checking bench for gpr_writeback.
// Checks are immediate assertions at each sample point.
module tb_gpr_writeback;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_waddr_i;
  logic [63:0] alu_wdata_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_waddr_i;
  logic [63:0] lsu_wdata_i;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [63:0] reg_wdata_o;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        rs1_pend_o;
  logic        rs2_pend_o;
  logic [63:0] rs1_fwd_o;
  logic [63:0] rs2_fwd_o;
  logic        wb_empty_o;
  logic        wb_full_o;

  int total = 0;
  int fails = 0;

  gpr_writeback #(.DEPTH(4), .DATA_W(64), .ADDR_W(5)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_ready_o (alu_ready_o),
    .alu_waddr_i (alu_waddr_i),
    .alu_wdata_i (alu_wdata_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_waddr_i (lsu_waddr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .reg_wen_o   (reg_wen_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs1_pend_o  (rs1_pend_o),
    .rs2_pend_o  (rs2_pend_o),
    .rs1_fwd_o   (rs1_fwd_o),
    .rs2_fwd_o   (rs2_fwd_o),
    .wb_empty_o  (wb_empty_o),
    .wb_full_o   (wb_full_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [63:0] exp_fa;
  logic [63:0] exp_fb;

  initial begin
`ifdef WB_BYPASS_EN
    exp_fa = 64'hA;
    exp_fb = 64'hB;
`else
    exp_fa = 64'h0;
    exp_fb = 64'h0;
`endif
    wb_rst_i    = 1'b1;
    alu_valid_i = 1'b0;
    alu_waddr_i = '0;
    alu_wdata_i = '0;
    lsu_valid_i = 1'b0;
    lsu_waddr_i = '0;
    lsu_wdata_i = '0;
    rs1_addr_i  = '0;
    rs2_addr_i  = '0;

    tick();
    tick();
    chk("rst_alu_rdy", alu_ready_o, 0);
    chk("rst_lsu_rdy", lsu_ready_o, 0);
    wb_rst_i = 1'b0;
    settle();
    chk("rst_wen", reg_wen_o, 0);
    chk("rst_waddr", reg_waddr_o, 0);
    chk("rst_wdata", reg_wdata_o, 0);
    chk("rst_empty", wb_empty_o, 1);
    chk("rst_full", wb_full_o, 0);
    chk("rst_pend1", rs1_pend_o, 0);
    chk("rst_fwd1", rs1_fwd_o, 0);
    chk("rst_alu_rdy_rel", alu_ready_o, 1);
    chk("rst_lsu_rdy_rel", lsu_ready_o, 1);

    // Single ALU result.
    alu_valid_i = 1'b1;
    alu_waddr_i = 5'd3;
    alu_wdata_i = 64'h11;
    rs1_addr_i  = 5'd3;
    settle();
    chk("t1_alu_rdy", alu_ready_o, 1);
    tick();
    alu_valid_i = 1'b0;
    settle();
    chk("t1_wen", reg_wen_o, 1);
    chk("t1_waddr", reg_waddr_o, 3);
    chk("t1_wdata", reg_wdata_o, 64'h11);
    chk("t1_empty", wb_empty_o, 0);
    chk("t1_pend1", rs1_pend_o, 1);
    tick();
    chk("t1_empty2", wb_empty_o, 1);
    chk("t1_wen2", reg_wen_o, 0);
    chk("t1_pend1b", rs1_pend_o, 0);
    rs1_addr_i = '0;

    // LSU priority over ALU.
    lsu_valid_i = 1'b1;
    lsu_waddr_i = 5'd5;
    lsu_wdata_i = 64'h55;
    alu_valid_i = 1'b1;
    alu_waddr_i = 5'd4;
    alu_wdata_i = 64'h44;
    settle();
    chk("t2_lsu_rdy", lsu_ready_o, 1);
    chk("t2_alu_rdy", alu_ready_o, 0);
    tick();
    lsu_valid_i = 1'b0;
    settle();
    chk("t2_alu_rdy2", alu_ready_o, 1);
    chk("t2_waddr_lsu", reg_waddr_o, 5);
    chk("t2_wdata_lsu", reg_wdata_o, 64'h55);
    tick();
    alu_valid_i = 1'b0;
    settle();
    chk("t2_wen_alu", reg_wen_o, 1);
    chk("t2_waddr_alu", reg_waddr_o, 4);
    chk("t2_wdata_alu", reg_wdata_o, 64'h44);
    tick();
    chk("t2_empty", wb_empty_o, 1);

    // Continuous LSU stream: one in, one out per cycle.
    lsu_valid_i = 1'b1;
    lsu_waddr_i = 5'd8;
    lsu_wdata_i = 64'h100;
    tick();
    for (int i = 1; i < 6; i++) begin
      lsu_waddr_i = 5'(8 + i);
      lsu_wdata_i = 64'(256 + i);
      settle();
      chk("t3_wen", reg_wen_o, 1);
      chk("t3_waddr", reg_waddr_o, 64'(7 + i));
      chk("t3_wdata", reg_wdata_o, 64'(255 + i));
      chk("t3_full", wb_full_o, 0);
      chk("t3_rdy", lsu_ready_o, 1);
      tick();
    end
    lsu_valid_i = 1'b0;
    settle();
    chk("t3_last_waddr", reg_waddr_o, 13);
    chk("t3_last_wdata", reg_wdata_o, 64'h105);
    tick();
    chk("t3_empty", wb_empty_o, 1);

    // x0 write is dropped.
    alu_valid_i = 1'b1;
    alu_waddr_i = 5'd0;
    alu_wdata_i = 64'hFF;
    settle();
    chk("t4_alu_rdy", alu_ready_o, 1);
    tick();
    alu_valid_i = 1'b0;
    settle();
    chk("t4_empty", wb_empty_o, 1);
    chk("t4_wen", reg_wen_o, 0);

    // Hazard and forwarding on repeated rd=7.
    rs1_addr_i  = 5'd7;
    rs2_addr_i  = 5'd0;
    alu_valid_i = 1'b1;
    alu_waddr_i = 5'd7;
    alu_wdata_i = 64'hA;
    tick();
    alu_wdata_i = 64'hB;
    settle();
    chk("t5_pend1a", rs1_pend_o, 1);
    chk("t5_pend2a", rs2_pend_o, 0);
    chk("t5_fwd1a", rs1_fwd_o, exp_fa);
    chk("t5_fwd2a", rs2_fwd_o, 0);
    tick();
    alu_valid_i = 1'b0;
    settle();
    chk("t5_pend1b", rs1_pend_o, 1);
    chk("t5_fwd1b", rs1_fwd_o, exp_fb);
    chk("t5_wdata", reg_wdata_o, 64'hB);
    tick();
    chk("t5_pend1c", rs1_pend_o, 0);
    chk("t5_fwd1c", rs1_fwd_o, 0);
    rs1_addr_i = '0;

    // Reset with a write buffered.
    alu_valid_i = 1'b1;
    alu_waddr_i = 5'd9;
    alu_wdata_i = 64'h99;
    tick();
    alu_valid_i = 1'b0;
    wb_rst_i    = 1'b1;
    settle();
    chk("t6_alu_rdy_rst", alu_ready_o, 0);
    chk("t6_lsu_rdy_rst", lsu_ready_o, 0);
    tick();
    wb_rst_i = 1'b0;
    settle();
    chk("t6_wen", reg_wen_o, 0);
    chk("t6_empty", wb_empty_o, 1);
    chk("t6_waddr", reg_waddr_o, 0);
    chk("t6_alu_rdy", alu_ready_o, 1);
    chk("t6_lsu_rdy", lsu_ready_o, 1);
    tick();
    chk("t6_wen2", reg_wen_o, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
